// File: rtl/sdram_init_flash_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_flash_loader_if
// Brief    : SDRAM controller init-load handshake (request/address, data/ready).
// Revision : 1.0 - initial release
// ============================================================================
interface sdram_init_flash_loader_if;
   logic        init_req;
   logic [20:0] init_address;
   logic [7:0]  init_data;
   logic        init_ready;

   modport master (
      output init_req,
      output init_address,
      input  init_data,
      input  init_ready
   );

   modport slave (
      input  init_req,
      input  init_address,
      output init_data,
      output init_ready
   );
endinterface
`default_nettype wire

// File: rtl/sdram_init_flash_loader.sv
`default_nettype none
// ============================================================================
// Module   : sdram_init_flash_loader
// Brief    : Serves SDRAM init-load requests with single-byte SPI NOR READ (0x03)
//            fetches, mode 0. Define INIT_LOADER_STREAM_EN for sequential streaming.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_init_flash_loader #(
   parameter logic [23:0] FLASH_BASE = 24'h100000,
   parameter int unsigned SCK_DIV    = 2
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   sdram_init_flash_loader_if.slave init_bus,
   output logic                     flash_cs_n,
   output logic                     flash_sck,
   output logic                     flash_mosi,
   input  wire logic                flash_miso
);

   localparam int unsigned T     = 2 * SCK_DIV;
   localparam int unsigned DIV_W = $clog2(T);

   localparam logic [DIV_W-1:0] C_RISE_PRE = DIV_W'(SCK_DIV - 1);
   localparam logic [DIV_W-1:0] C_RISE     = DIV_W'(SCK_DIV);
   localparam logic [DIV_W-1:0] C_LAST     = DIV_W'(T - 1);
   localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);
   localparam logic [7:0]       C_CMD_READ = 8'h03;

`ifdef INIT_LOADER_STREAM_EN
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_CMD      = 3'd2,
      ST_ADDR     = 3'd3,
      ST_DATA     = 3'd4,
      ST_DONE     = 3'd5,
      ST_DESELECT = 3'd6,
      ST_HOLD     = 3'd7
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_CMD      = 3'd2,
      ST_ADDR     = 3'd3,
      ST_DATA     = 3'd4,
      ST_DONE     = 3'd5,
      ST_DESELECT = 3'd6
   } state_t;
`endif

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q,   div_d;
   logic [4:0]         bit_q,   bit_d;
   logic [31:0]        tx_q,    tx_d;
   logic [7:0]         rx_q,    rx_d;
   logic [7:0]         data_q,  data_d;
   logic               ready_q, ready_d;
   logic               cs_n_q,  cs_n_d;
   logic               sck_q,   sck_d;
   logic               mosi_q,  mosi_d;

`ifdef INIT_LOADER_STREAM_EN
   logic [20:0]        last_q,  last_d;
   logic               vld_q,   vld_d;
   logic               hit_q,   hit_d;
   logic               pend_q,  pend_d;
   logic               w_hit;
`endif

   logic               w_req;
   logic [20:0]        w_addr;
   logic [23:0]        w_flash_addr;
   logic               w_cell_end;
   logic [7:0]         w_rx_shift;
   logic [7:0]         w_rx_cur;

   assign w_req        = init_bus.init_req;
   assign w_addr       = init_bus.init_address;
   assign w_flash_addr = FLASH_BASE + {3'b000, w_addr};
   assign w_cell_end   = (div_q == C_LAST);
   assign w_rx_shift   = {rx_q[6:0], flash_miso};
   // With SCK_DIV=1 the final sample lands in the same cycle the byte is stored.
   assign w_rx_cur     = (div_q == C_RISE) ? w_rx_shift : rx_q;

`ifdef INIT_LOADER_STREAM_EN
   assign w_hit = vld_q && (last_q != 21'h1FFFFF) && (w_addr == last_q + 21'd1);
`endif

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      data_d  = data_q;
      ready_d = 1'b0;
      cs_n_d  = cs_n_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
`ifdef INIT_LOADER_STREAM_EN
      last_d  = last_q;
      vld_d   = vld_q;
      hit_d   = hit_q;
      pend_d  = pend_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (w_req) begin
               state_d = ST_SETUP;
               cs_n_d  = 1'b0;
               tx_d    = {C_CMD_READ, w_flash_addr};
`ifdef INIT_LOADER_STREAM_EN
               last_d  = w_addr;
               hit_d   = 1'b0;
`endif
            end
         end

         ST_SETUP: begin
            div_d   = '0;
            bit_d   = '0;
            state_d = ST_CMD;
            mosi_d  = tx_q[31];
            tx_d    = {tx_q[30:0], 1'b0};
`ifdef INIT_LOADER_STREAM_EN
            // Stream continuation: flash already sits at the next byte.
            if (hit_q) begin
               state_d = ST_DATA;
               mosi_d  = 1'b0;
               tx_d    = tx_q;
            end
`endif
         end

         ST_CMD, ST_ADDR: begin
            div_d = div_q + C_DIV_ONE;
            if (div_q == C_RISE_PRE) begin
               sck_d = 1'b1;
            end
            if (w_cell_end) begin
               div_d  = '0;
               sck_d  = 1'b0;
               bit_d  = bit_q + 5'd1;
               mosi_d = tx_q[31];
               tx_d   = {tx_q[30:0], 1'b0};
               if ((state_q == ST_CMD) && (bit_q == 5'd7)) begin
                  state_d = ST_ADDR;
                  bit_d   = '0;
               end
               if ((state_q == ST_ADDR) && (bit_q == 5'd23)) begin
                  state_d = ST_DATA;
                  bit_d   = '0;
                  mosi_d  = 1'b0;
               end
            end
         end

         ST_DATA: begin
            div_d = div_q + C_DIV_ONE;
            if (div_q == C_RISE_PRE) begin
               sck_d = 1'b1;
            end
            if (div_q == C_RISE) begin
               rx_d = w_rx_shift;
            end
            if (w_cell_end) begin
               div_d = '0;
               sck_d = 1'b0;
               bit_d = bit_q + 5'd1;
               if (bit_q == 5'd7) begin
                  state_d = ST_DONE;
                  data_d  = w_rx_cur;
                  ready_d = 1'b1;
               end
            end
         end

         ST_DONE: begin
`ifdef INIT_LOADER_STREAM_EN
            state_d = ST_HOLD;
            vld_d   = 1'b1;
`else
            state_d = ST_DESELECT;
            cs_n_d  = 1'b1;
            div_d   = '0;
`endif
         end

`ifdef INIT_LOADER_STREAM_EN
         ST_HOLD: begin
            if (w_req) begin
               tx_d   = {C_CMD_READ, w_flash_addr};
               last_d = w_addr;
               if (w_hit) begin
                  state_d = ST_SETUP;
                  hit_d   = 1'b1;
               end else begin
                  state_d = ST_DESELECT;
                  cs_n_d  = 1'b1;
                  div_d   = '0;
                  pend_d  = 1'b1;
                  vld_d   = 1'b0;
                  hit_d   = 1'b0;
               end
            end
         end
`endif

         ST_DESELECT: begin
            div_d = div_q + C_DIV_ONE;
            if (w_cell_end) begin
               div_d   = '0;
               state_d = ST_IDLE;
`ifdef INIT_LOADER_STREAM_EN
               // A stream miss restarts with a full command without waiting in IDLE.
               if (pend_q) begin
                  state_d = ST_SETUP;
                  cs_n_d  = 1'b0;
                  pend_d  = 1'b0;
               end
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         data_q  <= 8'h00;
         ready_q <= 1'b0;
         cs_n_q  <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
`ifdef INIT_LOADER_STREAM_EN
         last_q  <= '0;
         vld_q   <= 1'b0;
         hit_q   <= 1'b0;
         pend_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         cs_n_q  <= cs_n_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
`ifdef INIT_LOADER_STREAM_EN
         last_q  <= last_d;
         vld_q   <= vld_d;
         hit_q   <= hit_d;
         pend_q  <= pend_d;
`endif
      end
   end

   assign flash_cs_n          = cs_n_q;
   assign flash_sck           = sck_q;
   assign flash_mosi          = mosi_q;
   assign init_bus.init_data  = data_q;
   assign init_bus.init_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_flash_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_init_flash_loader
// Brief    : Directed bench for sdram_init_flash_loader with a mode-0 SPI NOR model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_init_flash_loader;

   localparam logic [23:0] BASE_M = 24'h100000;
   localparam logic [23:0] BASE_W = 24'hFFFFF0;
`ifdef INIT_LOADER_STREAM_EN
   localparam bit STREAM = 1'b1;
`else
   localparam bit STREAM = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_init_flash_loader_if bus_m ();
   sdram_init_flash_loader_if bus_w ();

   logic cs_m, sck_m, mosi_m;
   logic miso_m = 1'b0;
   logic cs_w, sck_w, mosi_w;

   sdram_init_flash_loader #(.FLASH_BASE(BASE_M), .SCK_DIV(2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_bus   (bus_m),
      .flash_cs_n (cs_m),
      .flash_sck  (sck_m),
      .flash_mosi (mosi_m),
      .flash_miso (miso_m)
   );

   sdram_init_flash_loader #(.FLASH_BASE(BASE_W), .SCK_DIV(2)) u_dut_w (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_bus   (bus_w),
      .flash_cs_n (cs_w),
      .flash_sck  (sck_w),
      .flash_mosi (mosi_w),
      .flash_miso (1'b0)
   );

   function automatic logic [7:0] fbyte(input logic [23:0] a);
      if (a == 24'h100010) return 8'hA5;
      if (a == 24'h100011) return 8'h3C;
      return a[7:0] ^ 8'h5A;
   endfunction

   // Flash model: 32 command/address bits in, then bytes out MSB first on SCK falls.
   int          fl_cnt  = 0;
   int          fl_dbit = 0;
   logic [31:0] fl_sh   = '0;
   logic [31:0] fl_cmd  = '0;
   logic [23:0] fl_ptr  = '0;
   logic [7:0]  fl_byte;

   always @(negedge cs_m or posedge sck_m) begin
      if (sck_m && !cs_m) begin
         if (fl_cnt < 32) begin
            fl_sh  = {fl_sh[30:0], mosi_m};
            fl_cnt = fl_cnt + 1;
            if (fl_cnt == 32) begin
               fl_cmd  = fl_sh;
               fl_ptr  = fl_sh[23:0];
               fl_dbit = 0;
            end
         end else begin
            fl_dbit = fl_dbit + 1;
            if (fl_dbit == 8) begin
               fl_dbit = 0;
               fl_ptr  = fl_ptr + 24'd1;
            end
         end
      end else if (!cs_m) begin
         fl_cnt = 0;
      end
   end

   always @(negedge sck_m) begin
      if (!cs_m && fl_cnt == 32) begin
         fl_byte = fbyte(fl_ptr);
         miso_m  = fl_byte[7 - fl_dbit];
      end
   end

   int          w_cnt = 0;
   logic [31:0] w_sh  = '0;
   always @(negedge cs_w or posedge sck_w) begin
      if (sck_w && !cs_w) begin
         if (w_cnt < 32) begin
            w_sh  = {w_sh[30:0], mosi_w};
            w_cnt = w_cnt + 1;
         end
      end else if (!cs_w) begin
         w_cnt = 0;
      end
   end

   int sck_rises = 0;
   int ready_cnt = 0;
   always @(posedge sck_m) sck_rises = sck_rises + 1;
   always @(negedge clk) if (bus_m.init_ready) ready_cnt = ready_cnt + 1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt = total_cnt + 1;
      if (act === exp) pass_cnt = pass_cnt + 1;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic do_req(input logic [20:0] a, output int lat, output logic [7:0] d,
                         output int cs_hi, output int rises, output logic rdy_after);
      int n;
      int r0;
      lat   = -1;
      d     = 8'h00;
      cs_hi = 0;
      n     = 0;
      @(negedge clk);
      r0 = sck_rises;
      bus_m.init_req     = 1'b1;
      bus_m.init_address = a;
      while (lat < 0 && n < 400) begin
         @(negedge clk);
         n = n + 1;
         bus_m.init_req = 1'b0;
         if (cs_m) cs_hi = cs_hi + 1;
         if (bus_m.init_ready) begin
            lat = n;
            d   = bus_m.init_data;
         end
      end
      rises = sck_rises - r0;
      @(negedge clk);
      rdy_after = bus_m.init_ready;
   endtask

   typedef struct {
      logic [20:0] addr;
      int          lat;
      logic [7:0]  data;
      logic        full;
      logic [31:0] cmd;
      int          cs_hi;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          cs_hi;
      int          rises;
      int          r0;
      int          n;
      logic [7:0]  d;
      logic        rdy_after;
      logic [20:0] a;

`ifdef INIT_LOADER_STREAM_EN
      vecs.push_back('{21'h000010, 162, 8'hA5, 1'b1, 32'h03100010, 0});
      vecs.push_back('{21'h000011,  34, 8'h3C, 1'b0, 32'h00000000, 0});
      vecs.push_back('{21'h000040, 166, 8'h1A, 1'b1, 32'h03100040, 4});
      vecs.push_back('{21'h000041,  34, 8'h1B, 1'b0, 32'h00000000, 0});
      vecs.push_back('{21'h1FFFFF, 166, 8'hA5, 1'b1, 32'h032FFFFF, 4});
      vecs.push_back('{21'h000000, 166, 8'h5A, 1'b1, 32'h03100000, 4});
`else
      vecs.push_back('{21'h000010, 162, 8'hA5, 1'b1, 32'h03100010, 0});
      vecs.push_back('{21'h000011, 162, 8'h3C, 1'b1, 32'h03100011, 0});
      vecs.push_back('{21'h000040, 162, 8'h1A, 1'b1, 32'h03100040, 0});
      vecs.push_back('{21'h1FFFFF, 162, 8'hA5, 1'b1, 32'h032FFFFF, 0});
      vecs.push_back('{21'h000000, 162, 8'h5A, 1'b1, 32'h03100000, 0});
`endif

      bus_m.init_req     = 1'b0;
      bus_m.init_address = '0;
      bus_w.init_req     = 1'b0;
      bus_w.init_address = '0;

      repeat (3) @(negedge clk);
      chk("reset cs_n",  32'(cs_m),               32'd1);
      chk("reset sck",   32'(sck_m),              32'd0);
      chk("reset mosi",  32'(mosi_m),             32'd0);
      chk("reset ready", 32'(bus_m.init_ready),   32'd0);
      chk("reset data",  32'(bus_m.init_data),    32'h00);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      do_req(21'h000080, lat, d, cs_hi, rises, rdy_after);
      chk("pre read latency", 32'(lat), 32'd162);
      chk("pre read data",    32'(d),   32'hDA);
      repeat (8) @(negedge clk);

      // Abort a read in mid-ADDR with SCK high, then reset asynchronously.
      @(negedge clk);
      bus_m.init_req     = 1'b1;
      bus_m.init_address = 21'h000090;
      for (int i = 1; i <= 56 + (STREAM ? 4 : 0); i++) begin
         @(negedge clk);
         bus_m.init_req = 1'b0;
      end
      chk("mid-addr sck before reset",  32'(sck_m), 32'd1);
      chk("mid-addr cs_n before reset", 32'(cs_m),  32'd0);
      rst_n = 1'b0;
      #1;
      chk("async reset cs_n",  32'(cs_m),             32'd1);
      chk("async reset sck",   32'(sck_m),            32'd0);
      chk("async reset mosi",  32'(mosi_m),           32'd0);
      chk("async reset ready", 32'(bus_m.init_ready), 32'd0);
      chk("async reset data",  32'(bus_m.init_data),  32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      foreach (vecs[i]) begin
         do_req(vecs[i].addr, lat, d, cs_hi, rises, rdy_after);
         chk($sformatf("vec%0d latency", i),    32'(lat),       32'(vecs[i].lat));
         chk($sformatf("vec%0d data", i),       32'(d),         32'(vecs[i].data));
         chk($sformatf("vec%0d cs_n high", i),  32'(cs_hi),     32'(vecs[i].cs_hi));
         chk($sformatf("vec%0d sck rises", i),  32'(rises),     vecs[i].full ? 32'd40 : 32'd8);
         chk($sformatf("vec%0d ready width", i), 32'(rdy_after), 32'd0);
         if (vecs[i].full) begin
            chk($sformatf("vec%0d mosi cmd+addr", i), fl_cmd, vecs[i].cmd);
         end
         repeat (8) @(negedge clk);
      end

      // 24-bit wrap of FLASH_BASE + address on the second instance.
      @(negedge clk);
      bus_w.init_req     = 1'b1;
      bus_w.init_address = 21'h000020;
      lat = -1;
      n   = 0;
      d   = 8'hFF;
      while (lat < 0 && n < 400) begin
         @(negedge clk);
         n = n + 1;
         bus_w.init_req = 1'b0;
         if (bus_w.init_ready) begin
            lat = n;
            d   = bus_w.init_data;
         end
      end
      chk("wrap latency",        32'(lat), 32'd162);
      chk("wrap mosi cmd+addr",  w_sh,     32'h03000010);
      chk("wrap data",           32'(d),   32'h00);

      r0 = ready_cnt;
      for (int i = 0; i < 256; i++) begin
         a = 21'h000100 + 21'(i);
         do_req(a, lat, d, cs_hi, rises, rdy_after);
         chk($sformatf("seq %0d data", i), 32'(d), 32'(fbyte(BASE_M + {3'b000, a})));
         repeat (6) @(negedge clk);
      end
      repeat (20) @(negedge clk);
      chk("seq ready pulse count", 32'(ready_cnt - r0), 32'd256);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
